// File: rtl/rv_fanout_ctrl.sv
// Ready-valid eager-fork broadcast controller: one producer, up to NUM_OUT consumers.
// Tracks per-consumer delivery and applies fanout-mask changes only at token boundaries.
module rv_fanout_ctrl #(
    parameter int NUM_OUT = 7,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_wr,
    input  logic [NUM_OUT-1:0] cfg_mask,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [NUM_OUT-1:0] act_mask,
    output logic               cfg_pending,
    output logic               busy,
    output logic [CNT_W-1:0]   token_count
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PARTIAL = 1'b1
    } state_e;

    logic [NUM_OUT-1:0] act_mask_q, act_mask_d;
    logic [NUM_OUT-1:0] done_q, done_d;
    logic [NUM_OUT-1:0] shadow_mask_q, shadow_mask_d;
    logic               cfg_pending_q, cfg_pending_d;
    logic [CNT_W-1:0]   token_count_q, token_count_d;

    logic [NUM_OUT-1:0] accept_s;
    logic               retire_s;
    state_e             state_s;

    // Per-consumer handshakes and the upstream retire condition
    always_comb begin
        out_valid = {NUM_OUT{in_valid}} & act_mask_q & ~done_q;
        accept_s  = out_valid & out_ready;
        in_ready  = &(~act_mask_q | done_q | out_ready);
        retire_s  = in_valid & in_ready;
        if (done_q == {NUM_OUT{1'b0}}) begin
            state_s = ST_IDLE;
        end else begin
            state_s = ST_PARTIAL;
        end
    end

    // Next-state logic: flush beats retire beats delivery tracking
    always_comb begin
        act_mask_d    = act_mask_q;
        done_d        = done_q;
        shadow_mask_d = shadow_mask_q;
        cfg_pending_d = cfg_pending_q;
        token_count_d = token_count_q;

        if (flush) begin
            done_d = {NUM_OUT{1'b0}};
            if (cfg_wr) begin
                act_mask_d    = cfg_mask;
                cfg_pending_d = 1'b0;
            end else if (cfg_pending_q) begin
                act_mask_d    = shadow_mask_q;
                cfg_pending_d = 1'b0;
            end else begin
                act_mask_d    = act_mask_q;
            end
        end else if (retire_s) begin
            done_d        = {NUM_OUT{1'b0}};
            token_count_d = token_count_q + CNT_W'(1);
            cfg_pending_d = 1'b0;
            if (cfg_wr) begin
                act_mask_d = cfg_mask;
            end else if (cfg_pending_q) begin
                act_mask_d = shadow_mask_q;
            end else begin
                act_mask_d = act_mask_q;
            end
        end else begin
            done_d = done_q | accept_s;
            if (cfg_wr) begin
                // A write may only take effect immediately if no delivery has begun
                case (state_s)
                    ST_IDLE: begin
                        if (accept_s == {NUM_OUT{1'b0}}) begin
                            act_mask_d = cfg_mask;
                        end else begin
                            shadow_mask_d = cfg_mask;
                            cfg_pending_d = 1'b1;
                        end
                    end
                    ST_PARTIAL: begin
                        shadow_mask_d = cfg_mask;
                        cfg_pending_d = 1'b1;
                    end
                    default: begin
                        shadow_mask_d = cfg_mask;
                        cfg_pending_d = 1'b1;
                    end
                endcase
            end else begin
                shadow_mask_d = shadow_mask_q;
            end
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_mask_q    <= {NUM_OUT{1'b0}};
            done_q        <= {NUM_OUT{1'b0}};
            shadow_mask_q <= {NUM_OUT{1'b0}};
            cfg_pending_q <= 1'b0;
            token_count_q <= {CNT_W{1'b0}};
        end else begin
            act_mask_q    <= act_mask_d;
            done_q        <= done_d;
            shadow_mask_q <= shadow_mask_d;
            cfg_pending_q <= cfg_pending_d;
            token_count_q <= token_count_d;
        end
    end

    // Status outputs driven straight from registers
    always_comb begin
        act_mask    = act_mask_q;
        cfg_pending = cfg_pending_q;
        busy        = |done_q;
        token_count = token_count_q;
    end

endmodule

// File: tb/tb_rv_fanout_ctrl.sv
// Directed self-checking bench for rv_fanout_ctrl with four consumers.
module tb_rv_fanout_ctrl;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         cfg_wr;
    logic [N-1:0] cfg_mask;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out_valid;
    logic [N-1:0] out_ready;
    logic [N-1:0] act_mask;
    logic         cfg_pending;
    logic         busy;
    logic [W-1:0] token_count;

    int n_checks;
    int n_fail;
    int acc_cnt [N];
    logic count_en;

    rv_fanout_ctrl #(.NUM_OUT(N), .CNT_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_wr      (cfg_wr),
        .cfg_mask    (cfg_mask),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .act_mask    (act_mask),
        .cfg_pending (cfg_pending),
        .busy        (busy),
        .token_count (token_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tally accepts seen by each consumer while enabled
    always @(posedge clk) begin
        if (count_en) begin
            for (int i = 0; i < N; i++) begin
                acc_cnt[i] = acc_cnt[i] + int'(out_valid[i] & out_ready[i]);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        count_en = 1'b0;
        for (int i = 0; i < N; i++) acc_cnt[i] = 0;
        rst_n     = 1'b0;
        cfg_wr    = 1'b0;
        cfg_mask  = 4'b0000;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        #12;
        chk("rst_act_mask", 32'(act_mask), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_pending", 32'(cfg_pending), 32'h0);
        chk("rst_count", 32'(token_count), 32'h0);
        rst_n = 1'b1;
        next_cycle();

        // Empty mask: tokens retire immediately and go nowhere
        in_valid = 1'b1;
        #1;
        chk("empty_in_ready", 32'(in_ready), 32'h1);
        chk("empty_out_valid", 32'(out_valid), 32'h0);
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        chk("empty_count2", 32'(token_count), 32'h2);

        // Immediate mask write in IDLE, then full broadcast in one cycle
        cfg_wr   = 1'b1;
        cfg_mask = 4'b1011;
        next_cycle();
        cfg_wr = 1'b0;
        chk("idle_wr_mask", 32'(act_mask), 32'hb);
        chk("idle_wr_pending", 32'(cfg_pending), 32'h0);
        in_valid  = 1'b1;
        out_ready = 4'b1011;
        #1;
        chk("bcast_out_valid", 32'(out_valid), 32'hb);
        chk("bcast_in_ready", 32'(in_ready), 32'h1);
        next_cycle();
        chk("bcast_count", 32'(token_count), 32'h3);
        chk("bcast_busy", 32'(busy), 32'h0);

        // Eager fork: consumers take the token in three different cycles
        count_en  = 1'b1;
        out_ready = 4'b0001;
        #1;
        chk("fork0_in_ready", 32'(in_ready), 32'h0);
        next_cycle();
        chk("fork0_busy", 32'(busy), 32'h1);
        chk("fork0_out_valid", 32'(out_valid), 32'ha);
        out_ready = 4'b0010;
        #1;
        chk("fork1_in_ready", 32'(in_ready), 32'h0);
        next_cycle();
        chk("fork1_out_valid", 32'(out_valid), 32'h8);
        out_ready = 4'b1000;
        #1;
        chk("fork2_in_ready", 32'(in_ready), 32'h1);
        next_cycle();
        count_en = 1'b0;
        chk("fork2_busy", 32'(busy), 32'h0);
        chk("fork2_count", 32'(token_count), 32'h4);
        chk("fork2_out_valid", 32'(out_valid), 32'hb);
        chk("fork_acc0", 32'(acc_cnt[0]), 32'h1);
        chk("fork_acc1", 32'(acc_cnt[1]), 32'h1);
        chk("fork_acc2", 32'(acc_cnt[2]), 32'h0);
        chk("fork_acc3", 32'(acc_cnt[3]), 32'h1);

        // Mask write while busy is staged until the token retires
        out_ready = 4'b0001;
        next_cycle();
        cfg_wr    = 1'b1;
        cfg_mask  = 4'b0100;
        out_ready = 4'b0000;
        next_cycle();
        cfg_wr = 1'b0;
        chk("stage_pending", 32'(cfg_pending), 32'h1);
        chk("stage_act_hold", 32'(act_mask), 32'hb);
        chk("stage_busy", 32'(busy), 32'h1);
        out_ready = 4'b1010;
        next_cycle();
        out_ready = 4'b0000;
        chk("stage_apply_mask", 32'(act_mask), 32'h4);
        chk("stage_apply_pending", 32'(cfg_pending), 32'h0);
        chk("stage_count", 32'(token_count), 32'h5);
        #1;
        chk("stage_out_valid", 32'(out_valid), 32'h4);

        // Flush with a staged mask: partial delivery dropped, new mask applied
        in_valid = 1'b0;
        cfg_wr   = 1'b1;
        cfg_mask = 4'b0111;
        next_cycle();
        cfg_wr    = 1'b0;
        in_valid  = 1'b1;
        out_ready = 4'b0011;
        next_cycle();
        cfg_wr    = 1'b1;
        cfg_mask  = 4'b1100;
        out_ready = 4'b0000;
        next_cycle();
        cfg_wr = 1'b0;
        chk("flush_pre_pending", 32'(cfg_pending), 32'h1);
        chk("flush_pre_out_valid", 32'(out_valid), 32'h4);
        flush     = 1'b1;
        out_ready = 4'b0100;
        #1;
        chk("flush_retire_high", 32'(in_ready), 32'h1);
        next_cycle();
        flush     = 1'b0;
        out_ready = 4'b0000;
        #1;
        chk("flush_busy", 32'(busy), 32'h0);
        chk("flush_mask", 32'(act_mask), 32'hc);
        chk("flush_pending", 32'(cfg_pending), 32'h0);
        chk("flush_count", 32'(token_count), 32'h5);
        chk("flush_out_valid", 32'(out_valid), 32'hc);

        // Asynchronous reset in the middle of a partial delivery
        out_ready = 4'b0100;
        next_cycle();
        cfg_wr    = 1'b1;
        cfg_mask  = 4'b0001;
        out_ready = 4'b0000;
        next_cycle();
        cfg_wr = 1'b0;
        chk("arst_pre_busy", 32'(busy), 32'h1);
        chk("arst_pre_pending", 32'(cfg_pending), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_mask", 32'(act_mask), 32'h0);
        chk("arst_pending", 32'(cfg_pending), 32'h0);
        chk("arst_count", 32'(token_count), 32'h0);
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        in_valid = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
